g_mul32_seq: RTL and testbench

Sequential 32×32 unsigned shift-add multiplier producing a 64-bit product. It sits directly upstream of and around the existing gate-level `G_FullAdder32`. Each cycle it feeds that adder the running partial product and multiplicand, then registers the sum and carry-out. It gives the ALU a multiply path without a combinational array multiplier.

---
 rtl/g_mul32_pkg.sv | 13 +
 rtl/G_FullAdder32.sv | 27 ++
 rtl/g_mul32_seq.sv | 89 ++++++++
 tb/tb_g_mul32_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/g_mul32_pkg.sv
// Shared constants and state encoding for the sequential 32x32 multiplier.
package g_mul32_pkg;

  localparam int MUL_W = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/G_FullAdder32.sv
// Gate-level 32-bit ripple-carry adder; outputs forced low when disabled.
module G_FullAdder32 (
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic        CI,
  input  logic        Enable,
  output logic [31:0] Sum,
  output logic        CO
);

  logic [32:0] c;
  logic [31:0] s;

  assign c[0] = CI;

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_bit
      assign s[i]   = In1[i] ^ In2[i] ^ c[i];
      assign c[i+1] = (In1[i] & In2[i]) | (c[i] & (In1[i] ^ In2[i]));
    end
  endgenerate

  assign Sum = Enable ? s : 32'h0;
  assign CO  = Enable ? c[32] : 1'b0;

endmodule

// File: rtl/g_mul32_seq.sv
// Sequential 32x32 unsigned shift-add multiplier built around G_FullAdder32.
//
// state | meaning
// IDLE  | waiting for Start; operands latched on acceptance
// RUN   | one shift-add iteration per cycle, 32 iterations
// DONE  | Out valid, Done pulses for one cycle
import g_mul32_pkg::*;

module g_mul32_seq #(
  parameter int WIDTH = MUL_W
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   In1,
  input  logic [WIDTH-1:0]   In2,
  output logic [2*WIDTH-1:0] Out,
  output logic               Busy,
  output logic               Done
);

  state_t           state;
  logic [31:0]      a;
  logic [63:0]      p;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sum;
  logic             co;
  logic [63:0]      p_next;

  G_FullAdder32 u_adder (
    .In1    (p[63:32]),
    .In2    (a),
    .CI     (1'b0),
    .Enable (1'b1),
    .Sum    (sum),
    .CO     (co)
  );

  // The adder carry-out becomes P[63] when the multiplier bit is set.
  always_comb begin
    p_next = {1'b0, p[63:32], p[31:1]};
    if (p[0]) p_next = {co, sum, p[31:1]};
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      a     <= '0;
      p     <= '0;
      cnt   <= '0;
      Out   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a     <= In1;
            p     <= {32'h0, In2};
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MUL_W - 1)) begin
            Out   <= p_next;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_g_mul32_seq.sv
// Self-checking bench for g_mul32_seq: vector table, scoreboard queue, corner sequences.
module tb_g_mul32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [63:0] out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_out = 64'h0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[7];

  g_mul32_seq #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .Start (start),
    .In1   (in1),
    .In2   (in2),
    .Out   (out),
    .Busy  (busy),
    .Done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every Done pulse retires the oldest expected product.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        chk("product", out, exp_q.pop_front());
      end
    end
  end

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_mul(input logic [31:0] x, input logic [31:0] y, input logic [63:0] e);
    int n;
    @(negedge clk);
    in1 = x;
    in2 = y;
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    in1 = ~x;
    in2 = ~y;
    chk("busy_after_accept", {63'h0, busy}, 64'd1);
    chk("out_held", out, last_out);
    wait_done("mul", n);
    chk("latency", 64'(n), 64'd32);
    chk("busy_in_done", {63'h0, busy}, 64'd1);
    @(negedge clk);
    chk("done_one_cycle", {63'h0, done}, 64'd0);
    chk("busy_clear", {63'h0, busy}, 64'd0);
    chk("out_stable", out, e);
    last_out = e;
  endtask

  initial begin
    int n;
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    in1 = '0;
    in2 = '0;

    vecs[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000};
    vecs[3] = '{32'd0, 32'h1234_5678, 64'h0};
    vecs[4] = '{32'h1, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF};
    for (int i = 5; i < 7; i++) begin
      vecs[i].a = $urandom();
      vecs[i].b = $urandom();
      vecs[i].p = 64'(vecs[i].a) * 64'(vecs[i].b);
    end

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_out", out, 64'h0);
      chk("reset_busy", {63'h0, busy}, 64'd0);
      chk("reset_done", {63'h0, done}, 64'd0);
    end

    for (int i = 0; i < 7; i++) do_mul(vecs[i].a, vecs[i].b, vecs[i].p);

    // Start held high throughout; operand changes mid-run must not restart.
    @(negedge clk);
    in1 = 32'd7;
    in2 = 32'd6;
    start = 1'b1;
    exp_q.push_back(64'd42);
    exp_q.push_back(64'd81);
    repeat (6) @(negedge clk);
    in1 = 32'd9;
    in2 = 32'd9;
    wait_done("held1", n);
    chk("held_busy_in_done", {63'h0, busy}, 64'd1);
    @(negedge clk);
    chk("held_busy_clear", {63'h0, busy}, 64'd0);
    chk("held_done_low", {63'h0, done}, 64'd0);
    chk("held_out_first", out, 64'd42);
    @(negedge clk);
    chk("held_reaccept", {63'h0, busy}, 64'd1);
    chk("held_out_kept", out, 64'd42);
    wait_done("held2", n);
    start = 1'b0;
    @(negedge clk);
    chk("held_out_second", out, 64'd81);
    chk("held_busy_end", {63'h0, busy}, 64'd0);

    // Reset in the middle of a run aborts it.
    @(negedge clk);
    in1 = 32'd5;
    in2 = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_out_held", out, 64'd81);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out", out, 64'h0);
    chk("abort_busy", {63'h0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - dc), 64'd0);
    chk("abort_idle_busy", {63'h0, busy}, 64'd0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
